// File: rtl/femto_mem_arbiter.sv
// Two-master arbiter sharing one FemtoRV32-style memory port: captures strobe
// pulses into per-master slots and serialises them one transaction at a time.
module femto_mem_arbiter #(
    parameter int ADDR_WIDTH     = 24,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wmask,
    input  logic                  m0_rstrb,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rbusy,
    output logic                  m0_wbusy,

    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wmask,
    input  logic                  m1_rstrb,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rbusy,
    output logic                  m1_wbusy,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    output logic                  mem_rstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rbusy,
    input  logic                  mem_wbusy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic                  r_valid0;
    logic                  r_isWr0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [31:0]           r_wdata0;
    logic [3:0]            r_wmask0;
    logic [31:0]           r_rdata0;

    logic                  r_valid1;
    logic                  r_isWr1;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [31:0]           r_wdata1;
    logic [3:0]            r_wmask1;
    logic [31:0]           r_rdata1;

    logic                  r_owner;
    logic                  r_rrPtr;

    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [31:0]           r_memWdata;
    logic [3:0]            r_memWmask;
    logic                  r_memRstrb;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_pend0;
    logic                  w_pend1;
    logic                  w_cand0;
    logic                  w_cand1;
    logic                  w_strobeCycle;
    logic                  w_ownerWr;
    logic                  w_memDone;
    logic                  w_tiePick;
    logic                  w_arbSel;

    logic                  w_issue;
    logic                  w_sel;
    logic                  w_complete;

    logic [ADDR_WIDTH-1:0] w_srcAddr0;
    logic [31:0]           w_srcWdata0;
    logic [3:0]            w_srcWmask0;
    logic                  w_srcWr0;
    logic [ADDR_WIDTH-1:0] w_srcAddr1;
    logic [31:0]           w_srcWdata1;
    logic [3:0]            w_srcWmask1;
    logic                  w_srcWr1;

    logic [ADDR_WIDTH-1:0] w_issAddr;
    logic [31:0]           w_issWdata;
    logic [3:0]            w_issWmask;
    logic                  w_issWr;

    // A slot stays valid from capture until completion, so it doubles as the
    // "pending or active" flag that blocks further requests from that master.
    assign w_req0 = ~r_valid0 & (m0_rstrb | (m0_wmask != 4'b0000));
    assign w_req1 = ~r_valid1 & (m1_rstrb | (m1_wmask != 4'b0000));

    assign w_pend0 = r_valid0 & ~((r_state == WAIT) & ~r_owner);
    assign w_pend1 = r_valid1 & ~((r_state == WAIT) &  r_owner);

    assign w_cand0 = w_pend0 | w_req0;
    assign w_cand1 = w_pend1 | w_req1;

    assign w_strobeCycle = r_memRstrb | (r_memWmask != 4'b0000);
    assign w_ownerWr     = r_owner ? r_isWr1 : r_isWr0;
    assign w_memDone     = w_ownerWr ? ~mem_wbusy : ~mem_rbusy;

    // Pointer holds the master to favour on the next tie.
    assign w_tiePick = FIXED_PRIORITY ? 1'b0 : r_rrPtr;
    assign w_arbSel  = (w_cand0 & w_cand1) ? w_tiePick : w_cand1;

    // A request arriving this cycle bypasses its slot straight into issue.
    assign w_srcAddr0  = r_valid0 ? r_addr0  : m0_addr;
    assign w_srcWdata0 = r_valid0 ? r_wdata0 : m0_wdata;
    assign w_srcWmask0 = r_valid0 ? r_wmask0 : m0_wmask;
    assign w_srcWr0    = r_valid0 ? r_isWr0  : (m0_wmask != 4'b0000);
    assign w_srcAddr1  = r_valid1 ? r_addr1  : m1_addr;
    assign w_srcWdata1 = r_valid1 ? r_wdata1 : m1_wdata;
    assign w_srcWmask1 = r_valid1 ? r_wmask1 : m1_wmask;
    assign w_srcWr1    = r_valid1 ? r_isWr1  : (m1_wmask != 4'b0000);

    assign w_issAddr  = w_sel ? w_srcAddr1  : w_srcAddr0;
    assign w_issWdata = w_sel ? w_srcWdata1 : w_srcWdata0;
    assign w_issWmask = w_sel ? w_srcWmask1 : w_srcWmask0;
    assign w_issWr    = w_sel ? w_srcWr1    : w_srcWr0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Busy is ignored during the strobe cycle itself; at completion the other
    // master's pending slot is issued back-to-back without visiting IDLE.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_sel       = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cand0 | w_cand1) begin
                    w_issue     = 1'b1;
                    w_sel       = w_arbSel;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (!w_strobeCycle && w_memDone) begin
                    w_complete = 1'b1;
                    if (r_owner ? w_pend0 : w_pend1) begin
                        w_issue = 1'b1;
                        w_sel   = ~r_owner;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWmask <= 4'b0000;
            r_memRstrb <= 1'b0;
            r_owner    <= 1'b0;
            r_rrPtr    <= 1'b0;
        end else begin
            r_memWmask <= 4'b0000;
            r_memRstrb <= 1'b0;
            if (w_issue) begin
                r_memAddr  <= w_issAddr;
                r_memWdata <= w_issWdata;
                if (w_issWr) begin
                    r_memWmask <= w_issWmask;
                end else begin
                    r_memRstrb <= 1'b1;
                end
                r_owner <= w_sel;
                r_rrPtr <= ~w_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid0 <= 1'b0;
            r_isWr0  <= 1'b0;
            r_addr0  <= '0;
            r_wdata0 <= '0;
            r_wmask0 <= 4'b0000;
            r_rdata0 <= '0;
        end else if (w_complete && !r_owner) begin
            r_valid0 <= 1'b0;
            if (!r_isWr0) begin
                r_rdata0 <= mem_rdata;
            end
        end else if (w_req0) begin
            r_valid0 <= 1'b1;
            r_isWr0  <= (m0_wmask != 4'b0000);
            r_addr0  <= m0_addr;
            r_wdata0 <= m0_wdata;
            r_wmask0 <= m0_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid1 <= 1'b0;
            r_isWr1  <= 1'b0;
            r_addr1  <= '0;
            r_wdata1 <= '0;
            r_wmask1 <= 4'b0000;
            r_rdata1 <= '0;
        end else if (w_complete && r_owner) begin
            r_valid1 <= 1'b0;
            if (!r_isWr1) begin
                r_rdata1 <= mem_rdata;
            end
        end else if (w_req1) begin
            r_valid1 <= 1'b1;
            r_isWr1  <= (m1_wmask != 4'b0000);
            r_addr1  <= m1_addr;
            r_wdata1 <= m1_wdata;
            r_wmask1 <= m1_wmask;
        end
    end

    assign m0_rdata = r_rdata0;
    assign m0_rbusy = r_valid0 & ~r_isWr0;
    assign m0_wbusy = r_valid0 &  r_isWr0;
    assign m1_rdata = r_rdata1;
    assign m1_rbusy = r_valid1 & ~r_isWr1;
    assign m1_wbusy = r_valid1 &  r_isWr1;

    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_wmask = r_memWmask;
    assign mem_rstrb = r_memRstrb;

endmodule

// File: tb/tb_femto_mem_arbiter.sv
// Directed bench driving a round-robin and a fixed-priority arbiter side by
// side, each against its own small latency-programmable memory model.
module tb_femto_mem_arbiter;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0Addr, m1Addr;
    logic [31:0]   m0Wdata, m1Wdata;
    logic [3:0]    m0Wmask, m1Wmask;
    logic          m0Rstrb, m1Rstrb;

    logic [31:0]   aM0Rdata, aM1Rdata, bM0Rdata, bM1Rdata;
    logic          aM0Rbusy, aM0Wbusy, aM1Rbusy, aM1Wbusy;
    logic          bM0Rbusy, bM0Wbusy, bM1Rbusy, bM1Wbusy;
    logic [AW-1:0] aMemAddr, bMemAddr;
    logic [31:0]   aMemWdata, bMemWdata, aMemRdata, bMemRdata;
    logic [3:0]    aMemWmask, bMemWmask;
    logic          aMemRstrb, bMemRstrb;
    logic          aMemRbusy, aMemWbusy, bMemRbusy, bMemWbusy;

    int latency = 0;
    int assertCount = 0;
    int failCount = 0;
    int cntA = 0, cntB = 0;
    logic outA = 1'b0, outWrA = 1'b0, outB = 1'b0, outWrB = 1'b0;
    int strobesA = 0, strobesB = 0, overlapA = 0, overlapB = 0;
    int baseA, baseB;

    always #5 clk = ~clk;

    femto_mem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIORITY(1'b0)) uA (
        .clk(clk), .reset(reset),
        .m0_addr(m0Addr), .m0_wdata(m0Wdata), .m0_wmask(m0Wmask), .m0_rstrb(m0Rstrb),
        .m0_rdata(aM0Rdata), .m0_rbusy(aM0Rbusy), .m0_wbusy(aM0Wbusy),
        .m1_addr(m1Addr), .m1_wdata(m1Wdata), .m1_wmask(m1Wmask), .m1_rstrb(m1Rstrb),
        .m1_rdata(aM1Rdata), .m1_rbusy(aM1Rbusy), .m1_wbusy(aM1Wbusy),
        .mem_addr(aMemAddr), .mem_wdata(aMemWdata), .mem_wmask(aMemWmask),
        .mem_rstrb(aMemRstrb), .mem_rdata(aMemRdata), .mem_rbusy(aMemRbusy),
        .mem_wbusy(aMemWbusy)
    );

    femto_mem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIORITY(1'b1)) uB (
        .clk(clk), .reset(reset),
        .m0_addr(m0Addr), .m0_wdata(m0Wdata), .m0_wmask(m0Wmask), .m0_rstrb(m0Rstrb),
        .m0_rdata(bM0Rdata), .m0_rbusy(bM0Rbusy), .m0_wbusy(bM0Wbusy),
        .m1_addr(m1Addr), .m1_wdata(m1Wdata), .m1_wmask(m1Wmask), .m1_rstrb(m1Rstrb),
        .m1_rdata(bM1Rdata), .m1_rbusy(bM1Rbusy), .m1_wbusy(bM1Wbusy),
        .mem_addr(bMemAddr), .mem_wdata(bMemWdata), .mem_wmask(bMemWmask),
        .mem_rstrb(bMemRstrb), .mem_rdata(bMemRdata), .mem_rbusy(bMemRbusy),
        .mem_wbusy(bMemWbusy)
    );

    function automatic logic [31:0] memData(input logic [AW-1:0] a);
        return (a == 24'h000104) ? 32'hDEADBEEF : {8'h10, a};
    endfunction

    assign aMemRdata = memData(aMemAddr);
    assign bMemRdata = memData(bMemAddr);
    assign aMemRbusy = outA & ~outWrA & (cntA != 0);
    assign aMemWbusy = outA &  outWrA & (cntA != 0);
    assign bMemRbusy = outB & ~outWrB & (cntB != 0);
    assign bMemWbusy = outB &  outWrB & (cntB != 0);

    // Each memory holds busy for `latency` cycles after a strobe and flags
    // any strobe that arrives while its previous transaction is unfinished.
    always @(posedge clk) begin
        if (reset) begin
            cntA <= 0;
            outA <= 1'b0;
            outWrA <= 1'b0;
        end else if (aMemRstrb || aMemWmask != 4'b0000) begin
            if (outA) overlapA <= overlapA + 1;
            outA <= 1'b1;
            outWrA <= (aMemWmask != 4'b0000);
            cntA <= latency;
            strobesA <= strobesA + 1;
        end else if (outA) begin
            if (cntA == 0) outA <= 1'b0;
            else cntA <= cntA - 1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            cntB <= 0;
            outB <= 1'b0;
            outWrB <= 1'b0;
        end else if (bMemRstrb || bMemWmask != 4'b0000) begin
            if (outB) overlapB <= overlapB + 1;
            outB <= 1'b1;
            outWrB <= (bMemWmask != 4'b0000);
            cntB <= latency;
            strobesB <= strobesB + 1;
        end else if (outB) begin
            if (cntB == 0) outB <= 1'b0;
            else cntB <= cntB - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Presents one cycle of request pulses, returning one cycle later.
    task automatic applyStimulus(input logic r0, input logic [3:0] wm0,
                                 input logic [AW-1:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic [3:0] wm1,
                                 input logic [AW-1:0] a1, input logic [31:0] d1);
        m0Rstrb = r0; m0Wmask = wm0; m0Addr = a0; m0Wdata = d0;
        m1Rstrb = r1; m1Wmask = wm1; m1Addr = a1; m1Wdata = d1;
        tick();
        m0Rstrb = 1'b0; m0Wmask = 4'b0000;
        m1Rstrb = 1'b0; m1Wmask = 4'b0000;
    endtask

    initial begin
        logic [AW-1:0] addrA, addrB;
        reset = 1'b1;
        m0Rstrb = 1'b0; m0Wmask = 4'b0000; m0Addr = '0; m0Wdata = '0;
        m1Rstrb = 1'b0; m1Wmask = 4'b0000; m1Addr = '0; m1Wdata = '0;
        repeat (3) tick();
        checkOutput("reset m0_rdata", aM0Rdata, 32'h0);
        checkOutput("reset busy", {aM0Rbusy, aM0Wbusy, aM1Rbusy, aM1Wbusy}, 32'h0);
        checkOutput("reset mem_addr", aMemAddr, 32'h0);
        checkOutput("reset strobes", {aMemRstrb, aMemWmask}, 32'h0);
        reset = 1'b0;
        tick();

        // Fresh pointer: every tie round goes m0 then m1 on both arbiters.
        for (int i = 0; i < 4; i++) begin
            addrA = 24'(32'h120 + 4 * i);
            addrB = 24'(32'h220 + 4 * i);
            applyStimulus(1'b1, 4'b0000, addrA, '0, 1'b1, 4'b0000, addrB, '0);
            checkOutput("rr first A", aMemAddr, 32'(addrA));
            checkOutput("rr first B", bMemAddr, 32'(addrA));
            tick(); tick();
            checkOutput("rr second strobe", aMemRstrb, 32'h1);
            checkOutput("rr second A", aMemAddr, 32'(addrB));
            tick(); tick();
        end
        checkOutput("rr m1_rdata", aM1Rdata, 32'h1000022C);

        // Single zero-wait read.
        applyStimulus(1'b1, 4'b0000, 24'h000104, '0, 1'b0, 4'b0000, '0, '0);
        checkOutput("rd strobe", aMemRstrb, 32'h1);
        checkOutput("rd addr", aMemAddr, 32'h000104);
        checkOutput("rd busy T+1", aM0Rbusy, 32'h1);
        tick();
        checkOutput("rd strobe T+2", aMemRstrb, 32'h0);
        checkOutput("rd busy T+2", aM0Rbusy, 32'h1);
        tick();
        checkOutput("rd busy T+3", aM0Rbusy, 32'h0);
        checkOutput("rd m0_rdata", aM0Rdata, 32'hDEADBEEF);
        checkOutput("rd m1_rdata kept", aM1Rdata, 32'h1000022C);

        // Last grant was m0: round-robin now favours m1, fixed still m0.
        applyStimulus(1'b1, 4'b0000, 24'h000110, '0, 1'b1, 4'b0000, 24'h000210, '0);
        checkOutput("tie RR grant", aMemAddr, 32'h000210);
        checkOutput("tie FP grant", bMemAddr, 32'h000110);
        tick(); tick();
        checkOutput("tie RR second", aMemAddr, 32'h000110);
        checkOutput("tie FP second", bMemAddr, 32'h000210);
        tick(); tick();
        checkOutput("tie A m0_rdata", aM0Rdata, 32'h10000110);
        checkOutput("tie A m1_rdata", aM1Rdata, 32'h10000210);
        checkOutput("tie B m1_rdata", bM1Rdata, 32'h10000210);

        // m1 write with three wait cycles.
        latency = 3;
        applyStimulus(1'b0, 4'b0000, '0, '0, 1'b0, 4'b0011, 24'h000200, 32'hCAFEF00D);
        checkOutput("wr wmask", aMemWmask, 32'h3);
        checkOutput("wr wdata", aMemWdata, 32'hCAFEF00D);
        checkOutput("wr addr", aMemAddr, 32'h000200);
        checkOutput("wr busy", {aM1Wbusy, aM1Rbusy}, 32'h2);
        tick();
        checkOutput("wr wmask S+1", aMemWmask, 32'h0);
        tick(); tick(); tick();
        checkOutput("wr busy at C", aM1Wbusy, 32'h1);
        tick();
        checkOutput("wr busy C+1", aM1Wbusy, 32'h0);
        checkOutput("wr m1_rdata kept", aM1Rdata, 32'h10000210);

        // m0 read stalls five cycles while an m1 read waits behind it.
        latency = 5;
        applyStimulus(1'b1, 4'b0000, 24'h000130, '0, 1'b0, 4'b0000, '0, '0);
        tick();
        latency = 0;
        applyStimulus(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 24'h000230, '0);
        checkOutput("stall m1 pending", aM1Rbusy, 32'h1);
        tick(); tick(); tick(); tick();
        checkOutput("stall no strobe at C", aMemRstrb, 32'h0);
        checkOutput("stall m0 busy at C", aM0Rbusy, 32'h1);
        tick();
        checkOutput("stall m1 strobe", aMemRstrb, 32'h1);
        checkOutput("stall m1 addr", aMemAddr, 32'h000230);
        checkOutput("stall m0 done", {aM0Rbusy, aM0Rdata}, {1'b0, 32'h10000130});
        tick(); tick();
        checkOutput("stall m1_rdata", aM1Rdata, 32'h10000230);
        checkOutput("stall m1 busy", aM1Rbusy, 32'h0);

        // Second m0 request while its first is outstanding is dropped.
        latency = 2;
        baseA = strobesA;
        applyStimulus(1'b1, 4'b0000, 24'h000140, '0, 1'b0, 4'b0000, '0, '0);
        applyStimulus(1'b1, 4'b0000, 24'h000144, '0, 1'b0, 4'b0000, '0, '0);
        repeat (6) tick();
        checkOutput("drop strobe count", 32'(strobesA - baseA), 32'h1);
        checkOutput("drop m0_rdata", aM0Rdata, 32'h10000140);
        checkOutput("drop m0 busy", aM0Rbusy, 32'h0);

        // Reset mid-transaction with m1 pending.
        latency = 4;
        applyStimulus(1'b1, 4'b0000, 24'h000150, '0, 1'b0, 4'b0000, '0, '0);
        applyStimulus(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 24'h000250, '0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rst busy A", {aM0Rbusy, aM0Wbusy, aM1Rbusy, aM1Wbusy}, 32'h0);
        checkOutput("rst busy B", {bM0Rbusy, bM0Wbusy, bM1Rbusy, bM1Wbusy}, 32'h0);
        checkOutput("rst strobes", {aMemRstrb, aMemWmask}, 32'h0);
        checkOutput("rst m0_rdata", aM0Rdata, 32'h0);
        reset = 1'b0;
        baseA = strobesA;
        baseB = strobesB;
        repeat (8) tick();
        checkOutput("rst no later strobe A", 32'(strobesA - baseA), 32'h0);
        checkOutput("rst no later strobe B", 32'(strobesB - baseB), 32'h0);
        checkOutput("overlap A", 32'(overlapA), 32'h0);
        checkOutput("overlap B", 32'(overlapB), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
